rf_wb_ctrl: RTL and testbench
=============================

// Module: rf_wb_ctrl
// PURPOSE
//  Writeback controller driving the register file write port (one-hot enables, global enable, data).
//  Merges ALU writebacks with out-of-order load data from the memory unit.
//  Buffers loads in a small FIFO and tracks pending destinations in a scoreboard.
//  Sits between the execute/memory stages and the register file.
// PARAMETERS
//  RW        16  register width
//  REGNO     8   number of registers
//  REGNO_LOG 3   log2(REGNO)
//  LQ_DEPTH  4   load FIFO depth, power of two, >=2
// PORTS
//  i_clk        in   1          clock, rising edge
//  i_rst_n      in   1          asynchronous reset, active low
//  i_alu_valid  in   1          ALU writeback request
//  i_alu_sel    in   REGNO_LOG  ALU destination register
//  i_alu_data   in   RW         ALU result
//  o_alu_stall  out  1          ALU request not accepted this cycle; ALU holds request
//  i_mem_valid  in   1          load data valid
//  o_mem_ready  out  1          load FIFO can accept (registered, = !full)
//  i_mem_sel    in   REGNO_LOG  load destination register
//  i_mem_data   in   RW         load data
//  i_claim      in   1          issue stage reserves destination i_claim_sel
//  i_claim_sel  in   REGNO_LOG  register being reserved
//  o_pending    out  REGNO      scoreboard, bit i = write to reg i outstanding
//  o_rf_ie      out  REGNO      one-hot write enable to register file
//  o_rf_gie     out  1          global write enable, high with any o_rf_ie bit
//  o_rf_d       out  RW         write data
// BEHAVIOUR
//  - Reset (async, i_rst_n=0): o_rf_ie=0, o_rf_gie=0, o_rf_d=0, o_pending=0, FIFO empty.
//    o_mem_ready=0 while in reset, 1 from first edge after release. Reset mid-operation drops queued loads.
//  - Load accept: i_mem_valid & o_mem_ready -> push {sel,data}. Push and pop in the same cycle are legal.
//  - Arbitration, once per cycle, single winner:
//    - FIFO full: FIFO head wins; o_alu_stall=1 if i_alu_valid.
//    - Else i_alu_valid: ALU wins; o_alu_stall=0.
//    - Else FIFO not empty: pop head.
//    - Else: idle.
//  - Output registered: the winner at edge N appears on o_rf_ie/o_rf_gie/o_rf_d for cycle N..N+1.
//    o_rf_ie is one-hot of the winner's sel. Idle cycle: o_rf_ie=0, o_rf_gie=0, o_rf_d holds its last value.
//  - Latency: ALU 1 cycle. Load without bypass: >=2 cycles (push, then pop).
//  - o_alu_stall is combinational from registered full flag and i_alu_valid only.
//  - FIFO pointers are REGNO_LOG-independent, LQ_DEPTH-wrapping; count 0..LQ_DEPTH.
//  - Scoreboard: at each edge, the bit of the committed sel is cleared; then i_claim sets bit i_claim_sel.
//    Claim and commit to the same reg in the same cycle leaves the bit set.
//  - Commit to an unclaimed reg is legal and leaves its bit 0.
// CONFIGURATION
//  RF_WB_BYPASS_EN defined: if the FIFO is empty, i_alu_valid=0 and i_mem_valid=1, the load goes straight
//    to the output register (1-cycle latency) and is not pushed.
//  RF_WB_BYPASS_EN undefined: every load passes through the FIFO.
//  All other behaviour is identical in both builds.
// TESTING
//  1 Reset: hold i_rst_n=0 with random inputs -> all outputs 0, o_mem_ready=0.
//    Release -> o_mem_ready=1 next cycle.
//  2 ALU write: i_alu_valid=1, sel=5, data=16'hBEEF for 1 cycle -> next cycle o_rf_ie=8'h20,
//    o_rf_gie=1, o_rf_d=16'hBEEF; following cycle o_rf_ie=0.
//  3 Load only: push sel=2, data=16'h1234 with ALU idle -> o_rf_ie=8'h04 after 2 edges without bypass,
//    after 1 edge with RF_WB_BYPASS_EN.
//  4 Full/priority: ALU valid every cycle, push 4 loads -> o_mem_ready=0 and o_alu_stall=1.
//    Head load commits next; ALU writes resume; loads drain in FIFO order.
//  5 Scoreboard: claim r3 -> o_pending=8'h08. ALU commit r3 -> 0.
//    Claim r3 and commit r3 in the same cycle -> stays 8'h08.
//  6 Reset mid-queue: 3 loads queued, pulse i_rst_n low -> FIFO empty, no further o_rf_gie pulses.

Source files
------------

// File: rtl/rf_wb_ctrl.sv
// Register-file writeback controller: merges ALU results with queued load data and tracks pending destinations.
// Optional build macro RF_WB_BYPASS_EN lets a load skip the empty FIFO straight to the write port.
module rf_wb_ctrl #(
  parameter int RW        = 16,
  parameter int REGNO     = 8,
  parameter int REGNO_LOG = 3,
  parameter int LQ_DEPTH  = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_alu_valid,
  input  logic [REGNO_LOG-1:0] i_alu_sel,
  input  logic [RW-1:0]        i_alu_data,
  output logic                 o_alu_stall,
  input  logic                 i_mem_valid,
  output logic                 o_mem_ready,
  input  logic [REGNO_LOG-1:0] i_mem_sel,
  input  logic [RW-1:0]        i_mem_data,
  input  logic                 i_claim,
  input  logic [REGNO_LOG-1:0] i_claim_sel,
  output logic [REGNO-1:0]     o_pending,
  output logic [REGNO-1:0]     o_rf_ie,
  output logic                 o_rf_gie,
  output logic [RW-1:0]        o_rf_d
);

  localparam int PW = $clog2(LQ_DEPTH);
  localparam int CW = $clog2(LQ_DEPTH + 1);
  localparam int EW = REGNO_LOG + RW;
  localparam logic [REGNO-1:0] ONE_HOT0 = REGNO'(1);

  typedef enum logic [1:0] {SRC_IDLE, SRC_ALU, SRC_FIFO, SRC_BYP} src_t;

  src_t                 src;
  logic [EW-1:0]        lq [LQ_DEPTH];
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        count, count_next;
  logic                 full_q, mem_ready_q;
  logic                 empty, push, pop, bypass;
  logic [REGNO_LOG-1:0] win_sel;
  logic [RW-1:0]        win_data;
  logic [REGNO-1:0]     commit_mask, claim_mask, pending_q, pending_next;
  logic [REGNO-1:0]     rf_ie_q;
  logic                 rf_gie_q;
  logic [RW-1:0]        rf_d_q;

  assign empty       = (count == '0);
  assign o_mem_ready = mem_ready_q;
  assign o_alu_stall = full_q & i_alu_valid;
  assign o_pending   = pending_q;
  assign o_rf_ie     = rf_ie_q;
  assign o_rf_gie    = rf_gie_q;
  assign o_rf_d      = rf_d_q;

  always_comb begin
    bypass = 1'b0;
`ifdef RF_WB_BYPASS_EN
    bypass = empty & ~i_alu_valid & i_mem_valid & mem_ready_q;
`else
    bypass = 1'b0;
`endif
  end

  assign push = i_mem_valid & mem_ready_q & ~bypass;

  // A full queue outranks the ALU so loads cannot be starved forever.
  always_comb begin
    src      = SRC_IDLE;
    win_sel  = '0;
    win_data = '0;
    if (full_q)           src = SRC_FIFO;
    else if (i_alu_valid) src = SRC_ALU;
    else if (!empty)      src = SRC_FIFO;
    else if (bypass)      src = SRC_BYP;
    case (src)
      SRC_ALU:  begin win_sel = i_alu_sel; win_data = i_alu_data; end
      SRC_FIFO: {win_sel, win_data} = lq[rd_ptr];
      SRC_BYP:  begin win_sel = i_mem_sel; win_data = i_mem_data; end
      default:  ;
    endcase
  end

  assign pop = (src == SRC_FIFO);

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  always_comb begin
    commit_mask  = (src != SRC_IDLE) ? (ONE_HOT0 << win_sel) : '0;
    claim_mask   = i_claim ? (ONE_HOT0 << i_claim_sel) : '0;
    pending_next = (pending_q & ~commit_mask) | claim_mask;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      full_q      <= 1'b0;
      mem_ready_q <= 1'b0;
      pending_q   <= '0;
      rf_ie_q     <= '0;
      rf_gie_q    <= 1'b0;
      rf_d_q      <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count       <= count_next;
      full_q      <= (count_next == CW'(LQ_DEPTH));
      mem_ready_q <= (count_next != CW'(LQ_DEPTH));
      pending_q   <= pending_next;
      if (src != SRC_IDLE) begin
        rf_ie_q  <= commit_mask;
        rf_gie_q <= 1'b1;
        rf_d_q   <= win_data;
      end else begin
        rf_ie_q  <= '0;
        rf_gie_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) lq[wr_ptr] <= {i_mem_sel, i_mem_data};
  end

endmodule

// File: tb/tb_rf_wb_ctrl.sv
// Directed self-checking bench for rf_wb_ctrl; expectations are hand-computed constants.
module tb_rf_wb_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid, mem_valid, claim;
  logic [2:0]  alu_sel, mem_sel, claim_sel;
  logic [15:0] alu_data, mem_data;
  logic        alu_stall, mem_ready, rf_gie;
  logic [7:0]  pending, rf_ie;
  logic [15:0] rf_d;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  rf_wb_ctrl #(.RW(16), .REGNO(8), .REGNO_LOG(3), .LQ_DEPTH(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_alu_valid(alu_valid), .i_alu_sel(alu_sel), .i_alu_data(alu_data), .o_alu_stall(alu_stall),
    .i_mem_valid(mem_valid), .o_mem_ready(mem_ready), .i_mem_sel(mem_sel), .i_mem_data(mem_data),
    .i_claim(claim), .i_claim_sel(claim_sel), .o_pending(pending),
    .o_rf_ie(rf_ie), .o_rf_gie(rf_gie), .o_rf_d(rf_d)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; outputs then reflect that edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_wb(input string tag, input logic [7:0] ie, input logic gie, input logic [15:0] d);
    check({tag, ".ie"},  32'(rf_ie),  32'(ie));
    check({tag, ".gie"}, 32'(rf_gie), 32'(gie));
    check({tag, ".d"},   32'(rf_d),   32'(d));
  endtask

  task automatic idle_inputs();
    alu_valid = 0; alu_sel = '0; alu_data = '0;
    mem_valid = 0; mem_sel = '0; mem_data = '0;
    claim = 0; claim_sel = '0;
  endtask

  initial begin
    rst_n = 0;
    idle_inputs();

    // 1: reset with random activity on inputs
    for (int i = 0; i < 4; i++) begin
      alu_valid = 1'($urandom); alu_sel = 3'($urandom); alu_data = 16'($urandom);
      mem_valid = 1'($urandom); mem_sel = 3'($urandom); mem_data = 16'($urandom);
      claim = 1'($urandom); claim_sel = 3'($urandom);
      step();
      check_wb("rst", 8'h00, 1'b0, 16'h0000);
      check("rst.pending", 32'(pending), 32'h0);
      check("rst.ready", 32'(mem_ready), 32'h0);
    end
    idle_inputs();
    rst_n = 1;
    step();
    check("rel.ready", 32'(mem_ready), 32'h1);
    check("rel.stall", 32'(alu_stall), 32'h0);

    // 2: single ALU write
    alu_valid = 1; alu_sel = 3'd5; alu_data = 16'hBEEF;
    step();
    alu_valid = 0;
    check_wb("alu", 8'h20, 1'b1, 16'hBEEF);
    step();
    check_wb("alu.idle", 8'h00, 1'b0, 16'hBEEF);

    // 3: lone load
    mem_valid = 1; mem_sel = 3'd2; mem_data = 16'h1234;
    step();
    mem_valid = 0;
`ifdef RF_WB_BYPASS_EN
    check_wb("ld.byp", 8'h04, 1'b1, 16'h1234);
    step();
    check_wb("ld.after", 8'h00, 1'b0, 16'h1234);
`else
    check_wb("ld.push", 8'h00, 1'b0, 16'hBEEF);
    step();
    check_wb("ld.pop", 8'h04, 1'b1, 16'h1234);
    step();
    check_wb("ld.after", 8'h00, 1'b0, 16'h1234);
`endif

    // 4: fill the queue under constant ALU traffic
    alu_valid = 1; alu_sel = 3'd6;
    for (int i = 0; i < 4; i++) begin
      alu_data  = 16'hC000 + 16'(i);
      mem_valid = 1; mem_sel = 3'(i + 1); mem_data = 16'hA001 + 16'(i);
      check("fill.ready", 32'(mem_ready), 32'h1);
      step();
      check_wb("fill.alu", 8'h40, 1'b1, 16'hC000 + 16'(i));
    end
    mem_valid = 0;
    alu_data  = 16'hC004;
    #1;
    check("full.ready", 32'(mem_ready), 32'h0);
    check("full.stall", 32'(alu_stall), 32'h1);
    step();
    check_wb("full.head", 8'h02, 1'b1, 16'hA001);
    check("drain.ready", 32'(mem_ready), 32'h1);
    check("drain.stall", 32'(alu_stall), 32'h0);
    step();
    check_wb("resume.alu", 8'h40, 1'b1, 16'hC004);
    alu_valid = 0;
    step();
    check_wb("drain.2", 8'h04, 1'b1, 16'hA002);
    step();
    check_wb("drain.3", 8'h08, 1'b1, 16'hA003);
    step();
    check_wb("drain.4", 8'h10, 1'b1, 16'hA004);
    step();
    check_wb("drain.idle", 8'h00, 1'b0, 16'hA004);

    // 5: scoreboard
    claim = 1; claim_sel = 3'd3;
    step();
    claim = 0;
    check("sb.claim", 32'(pending), 32'h08);
    alu_valid = 1; alu_sel = 3'd3; alu_data = 16'h3333;
    step();
    alu_valid = 0;
    check("sb.commit", 32'(pending), 32'h00);
    check_wb("sb.commit", 8'h08, 1'b1, 16'h3333);
    claim = 1; claim_sel = 3'd3;
    step();
    check("sb.reclaim", 32'(pending), 32'h08);
    alu_valid = 1; alu_sel = 3'd3; alu_data = 16'h4444;
    step();
    claim = 0;
    check("sb.same", 32'(pending), 32'h08);
    alu_sel = 3'd7; alu_data = 16'h7777;
    step();
    check("sb.unclaimed", 32'(pending), 32'h08);
    check_wb("sb.unclaimed", 8'h80, 1'b1, 16'h7777);
    alu_sel = 3'd3;
    step();
    alu_valid = 0;
    check("sb.clear", 32'(pending), 32'h00);
    step();

    // 6: reset with loads queued
    alu_valid = 1; alu_sel = 3'd0; alu_data = 16'h0F0F;
    for (int i = 0; i < 3; i++) begin
      mem_valid = 1; mem_sel = 3'(i + 1); mem_data = 16'hD000 + 16'(i);
      step();
    end
    idle_inputs();
    claim = 1; claim_sel = 3'd4;
    step();
    claim = 0;
    check("mq.pending", 32'(pending), 32'h10);
    rst_n = 0;
    #1;
    check_wb("mq.rst", 8'h00, 1'b0, 16'h0000);
    check("mq.rst.pending", 32'(pending), 32'h0);
    check("mq.rst.ready", 32'(mem_ready), 32'h0);
    step();
    rst_n = 1;
    for (int i = 0; i < 6; i++) begin
      step();
      check("mq.quiet", 32'(rf_gie), 32'h0);
    end
    check("mq.ready", 32'(mem_ready), 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
